// File: rtl/ram_burst_master.sv
// ram_burst_master
// ----------------
// Initiator-side burst controller for a single-port RAM with a registered
// read address (read data appears on ram_q the cycle after the address).
// Burst commands arrive on a valid/ready channel; write beats stream in on
// wr_*, read beats stream out of a 2-entry buffer on rd_*.
//
// Optional feature macro: RAM_BURST_MASTER_BOUND_EN
//   defined   : a burst that reaches the top address with beats remaining
//               ends after that beat, and err is set until reset.
//   undefined : addresses wrap modulo 2^ADDR_W and err is tied to 0.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready          command handshake (ready only when idle)
//   cmd_write/addr/len       burst direction, start address, beats minus 1
//   wr_data/valid/ready      write beat stream
//   rd_data/valid/ready      read beat stream (head of 2-entry buffer)
//   busy, err                not idle; sticky bound error
//   ram_addr/data/we         RAM pins; ram_q is the RAM read data
module ram_burst_master #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_MAX  = {ADDR_W{1'b1}};

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   ptr_r;
    logic [ADDR_W-1:0]   cnt_r;
    logic [ADDR_W-1:0]   ptr_next_s;
    logic                load_s;
    logic                beat_s;
    logic                issue_s;
    logic                bound_s;
    logic                pop_s;
    logic                room_s;
    logic                drain_done_s;
    logic [2:0]          credit_s;

    logic [DATA_W-1:0]   fifo_mem_r [0:1];
    logic                fifo_wp_r;
    logic                fifo_rp_r;
    logic [1:0]          fifo_cnt_r;
    logic                inflight_r;

    // The burst is cut short at the top address only when the bound check is built in.
`ifdef RAM_BURST_MASTER_BOUND_EN
    assign bound_s    = (ptr_r == PTR_MAX) && (cnt_r != PTR_ZERO);
    assign ptr_next_s = (ptr_r == PTR_MAX) ? ptr_r : (ptr_r + PTR_ONE);
`else
    assign bound_s    = 1'b0;
    assign ptr_next_s = ptr_r + PTR_ONE;
`endif

    // A beat popped this cycle frees its slot for an issue in the same cycle,
    // which is what lets reads stream at one beat per cycle.
    assign pop_s        = (fifo_cnt_r != 2'd0) && rd_ready;
    assign credit_s     = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign room_s       = (credit_s < 3'd2);
    assign drain_done_s = ((fifo_cnt_r - {1'b0, pop_s}) == 2'd0) && !inflight_r;

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        beat_s  = 1'b0;
        issue_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    load_s  = 1'b1;
                    state_s = cmd_write ? S_WRITE : S_READ;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WRITE: begin
                if (wr_valid) begin
                    beat_s = 1'b1;
                    if ((cnt_r == PTR_ZERO) || bound_s) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_WRITE;
                    end
                end else begin
                    state_s = S_WRITE;
                end
            end
            S_READ: begin
                if (room_s) begin
                    beat_s  = 1'b1;
                    issue_s = 1'b1;
                    if ((cnt_r == PTR_ZERO) || bound_s) begin
                        state_s = S_DRAIN;
                    end else begin
                        state_s = S_READ;
                    end
                end else begin
                    state_s = S_READ;
                end
            end
            S_DRAIN: begin
                if (drain_done_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Address pointer and remaining-beat count; the pointer is the RAM address.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= PTR_ZERO;
            cnt_r <= PTR_ZERO;
        end else if (load_s) begin
            ptr_r <= cmd_addr;
            cnt_r <= cmd_len;
        end else if (beat_s) begin
            ptr_r <= ptr_next_s;
            cnt_r <= cnt_r - PTR_ONE;
        end else begin
            ptr_r <= ptr_r;
            cnt_r <= cnt_r;
        end
    end

    // Read-in-flight flag: ram_q is valid the cycle after an issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
        end
    end

    // Read buffer pointers and occupancy; capture and pop may coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wp_r  <= 1'b0;
            fifo_rp_r  <= 1'b0;
            fifo_cnt_r <= 2'd0;
        end else begin
            fifo_wp_r  <= fifo_wp_r ^ inflight_r;
            fifo_rp_r  <= fifo_rp_r ^ pop_s;
            fifo_cnt_r <= fifo_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
        end
    end

    // Read buffer storage; contents are meaningless while the slot is empty.
    always_ff @(posedge clk) begin
        if (inflight_r) begin
            fifo_mem_r[fifo_wp_r] <= ram_q;
        end
    end

`ifdef RAM_BURST_MASTER_BOUND_EN
    logic err_r;

    // Sticky bound error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (beat_s && bound_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign cmd_ready = (state_r == S_IDLE);
    assign wr_ready  = (state_r == S_WRITE);
    assign busy      = (state_r != S_IDLE);
    assign ram_addr  = ptr_r;
    assign ram_data  = wr_data;
    assign ram_we    = wr_valid & wr_ready;
    assign rd_valid  = (fifo_cnt_r != 2'd0);
    assign rd_data   = fifo_mem_r[fifo_rp_r];

endmodule
